// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if -- board-side and program-memory-side signals of the
// switch-driven program loader, bundled as one interface.
//
// Parameters:
//   Psize : program address width (capacity 2^Psize words)
//   Isize : instruction word width
//
// Signals:
//   SW         board switches, the word to be written
//   load_btn   raw load push-button (asynchronous)
//   run_btn    raw run/load toggle push-button (asynchronous)
//   wr_en      one-cycle program-memory write strobe
//   wr_addr    program-memory write address
//   wr_data    program-memory write data
//   cpu_nReset reset to the CPU, low while loading
//   loading    high while the loader owns the program memory
//   full       every address has been written since LOAD was entered
//   checksum   running sum of written words (PROG_LOADER_CHECKSUM_EN only)
//
// Modports:
//   master : the loader (drives the write port and CPU reset)
//   slave  : the board / memory / CPU side
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the checksum signal.
// ---------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int Psize = 8,
  parameter int Isize = 8
);
  logic [Isize-1:0] SW;
  logic             load_btn;
  logic             run_btn;
  logic             wr_en;
  logic [Psize-1:0] wr_addr;
  logic [Isize-1:0] wr_data;
  logic             cpu_nReset;
  logic             loading;
  logic             full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [Isize-1:0] checksum;

  modport master (
    input  SW, load_btn, run_btn,
    output wr_en, wr_addr, wr_data, cpu_nReset, loading, full, checksum
  );

  modport slave (
    output SW, load_btn, run_btn,
    input  wr_en, wr_addr, wr_data, cpu_nReset, loading, full, checksum
  );
`else
  modport master (
    input  SW, load_btn, run_btn,
    output wr_en, wr_addr, wr_data, cpu_nReset, loading, full
  );

  modport slave (
    output SW, load_btn, run_btn,
    input  wr_en, wr_addr, wr_data, cpu_nReset, loading, full
  );
`endif
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- switch-driven program loader.
//
// While in LOAD the CPU is held in reset; each debounced press of the load
// button writes the switch word into the program memory at an
// auto-incrementing address. A debounced press of the run button releases
// the CPU (RUN); pressing it again returns to LOAD and restarts at address 0.
//
// Parameters:
//   Psize     : program address width
//   Isize     : instruction word width
//   DB_CYCLES : stable synchronized cycles needed to accept a button change
//               (>= 1)
//
// Ports:
//   clk    : system clock, rising edge
//   nReset : synchronous active-low reset
//   bus    : prog_loader_if.master -- switches, buttons, memory write port,
//            cpu_nReset, loading, full (and checksum when enabled)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- when defined, a running
// modulo-2^Isize sum of all words written since the last entry to LOAD is
// driven on bus.checksum.
//
// All outputs come straight from flops; nothing combinational reaches them.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int Psize     = 8,
  parameter int Isize     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          nReset,
  prog_loader_if.master bus
);

  // The debounce counter only ever holds 0 .. DB_CYCLES-1: it clears on the
  // cycle it would have reached DB_CYCLES.
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [Psize-1:0] ADDR_LAST = '1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Button conditioning: bit 0 = load, bit 1 = run.
  // -------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {bus.run_btn, bus.load_btn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_db_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!nReset) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_db_q <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= w_btn_raw[gi];
        r_s2   <= r_s1;
        r_db_q <= r_db;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // Only a rising debounced level counts; a held button stays one press.
    assign w_press[gi] = r_db & ~r_db_q;
  end

  logic w_load_press;
  logic w_run_press;

  assign w_load_press = w_press[0];
  assign w_run_press  = w_press[1];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: if (w_run_press) w_state_next = ST_RUN;
      ST_RUN:  if (w_run_press) w_state_next = ST_LOAD;
      default: w_state_next = ST_LOAD;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / datapath next values (registered below)
  // -------------------------------------------------------------------------
  logic             r_wr_en;
  logic [Psize-1:0] r_wr_addr;
  logic [Isize-1:0] r_wr_data;
  logic [Psize-1:0] r_addr;
  logic             r_full;
  logic             r_loading;
  logic             r_cpu_nreset;

  logic             w_do_write;
  logic             w_enter_load;
  logic             w_wr_en_next;
  logic [Psize-1:0] w_wr_addr_next;
  logic [Isize-1:0] w_wr_data_next;
  logic [Psize-1:0] w_addr_next;
  logic             w_full_next;
  logic             w_loading_next;
  logic             w_cpu_nreset_next;

  always_comb begin
    w_do_write        = (r_state == ST_LOAD) && w_load_press && !r_full;
    w_enter_load      = (r_state == ST_RUN) && w_run_press;
    w_wr_en_next      = w_do_write;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_addr_next       = r_addr;
    w_full_next       = r_full;
    w_loading_next    = (w_state_next == ST_LOAD);
    w_cpu_nreset_next = (w_state_next == ST_RUN);

    if (w_enter_load) begin
      // Fresh load session: start over at address 0.
      w_wr_addr_next = '0;
      w_addr_next    = '0;
      w_full_next    = 1'b0;
    end else if (w_do_write) begin
      w_wr_addr_next = r_addr;
      w_wr_data_next = bus.SW;
      // The last address saturates instead of wrapping; full blocks
      // further writes until the next LOAD entry.
      if (r_addr == ADDR_LAST) begin
        w_full_next = 1'b1;
      end else begin
        w_addr_next = r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_addr       <= '0;
      r_full       <= 1'b0;
      r_loading    <= 1'b1;
      r_cpu_nreset <= 1'b0;
    end else begin
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_addr       <= w_addr_next;
      r_full       <= w_full_next;
      r_loading    <= w_loading_next;
      r_cpu_nreset <= w_cpu_nreset_next;
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.full       = r_full;
  assign bus.loading    = r_loading;
  assign bus.cpu_nReset = r_cpu_nreset;

`ifdef PROG_LOADER_CHECKSUM_EN
  // -------------------------------------------------------------------------
  // Running checksum: accumulates the word on the write port during its
  // strobe cycle, so the sum includes it from the following cycle.
  // -------------------------------------------------------------------------
  logic [Isize-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_checksum <= '0;
    end else if (w_enter_load) begin
      r_checksum <= '0;
    end else if (r_wr_en) begin
      r_checksum <= r_checksum + r_wr_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader -- self-checking bench for prog_loader.
// A small behavioural model (expected address, full, state, checksum) pushes
// the expected {addr, data} of every write into a scoreboard queue; a
// monitor pops and compares whenever wr_en is seen high.
// ---------------------------------------------------------------------------
module tb_prog_loader;
  localparam int P    = 2;
  localparam int I    = 8;
  localparam int DB   = 4;
  localparam int MAXA = (1 << P) - 1;

  logic clk    = 1'b0;
  logic nReset = 1'b0;

  always #5 clk = ~clk;

  prog_loader_if #(.Psize(P), .Isize(I)) bus ();

  prog_loader #(.Psize(P), .Isize(I), .DB_CYCLES(DB)) u_dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int         exp_addr    = 0;
  logic       exp_full    = 1'b0;
  logic       exp_loading = 1'b1;
  logic [I-1:0] exp_cksum = '0;

  logic [P+I-1:0] sb_q[$];

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%0h data=%0h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        logic [P+I-1:0] e;
        e = sb_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          n_fail++;
          $display("FAIL write_addr_data got addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.wr_addr, bus.wr_data, e[P+I-1:I], e[I-1:0]);
        end else begin
          $display("[TB] write addr=%0h data=%0h ok", bus.wr_addr, bus.wr_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    nReset       = 1'b0;
    bus.load_btn = 1'b0;
    bus.run_btn  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nReset      = 1'b1;
    exp_addr    = 0;
    exp_full    = 1'b0;
    exp_loading = 1'b1;
    exp_cksum   = '0;
  endtask

  // Press load (optionally together with run) and check timing/width.
  task automatic press(input logic [I-1:0] sw, input logic with_load, input logic with_run);
    int   first_k;
    int   hi_cnt;
    int   tog_k;
    logic will_write;
    logic full_at_wr;
    logic cpu_at_tog;
    logic nxt_loading;
    will_write  = with_load && exp_loading && !exp_full;
    nxt_loading = with_run ? !exp_loading : exp_loading;
    if (will_write) begin
      logic [P-1:0] a;
      a = exp_addr[P-1:0];
      sb_q.push_back({a, sw});
      if (exp_addr == MAXA) exp_full = 1'b1;
      else exp_addr++;
      exp_cksum = exp_cksum + sw;
    end
    if (with_run && nxt_loading) begin
      exp_addr  = 0;
      exp_full  = 1'b0;
      exp_cksum = '0;
    end
    @(negedge clk);
    bus.SW       = sw;
    bus.load_btn = with_load;
    bus.run_btn  = with_run;
    first_k = -1; hi_cnt = 0; tog_k = -1; full_at_wr = 1'b0; cpu_at_tog = 1'b0;
    for (int k = 0; k < DB + 8; k++) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1) begin
        hi_cnt++;
        if (first_k < 0) begin
          first_k    = k;
          full_at_wr = bus.full;
        end
      end
      if (tog_k < 0 && bus.loading !== exp_loading) begin
        tog_k      = k;
        cpu_at_tog = bus.cpu_nReset;
      end
    end
    @(negedge clk);
    bus.load_btn = 1'b0;
    bus.run_btn  = 1'b0;
    repeat (DB + 6) @(posedge clk);
    #1;
    exp_loading = nxt_loading;
    if (with_load) begin
      n_tests++;
      if (will_write && (first_k != DB + 2 || hi_cnt != 1 || full_at_wr !== exp_full)) begin
        n_fail++;
        $display("FAIL load_press_timing got first=%0d pulses=%0d full=%b, required first=%0d pulses=1 full=%b",
                 first_k, hi_cnt, full_at_wr, DB + 2, exp_full);
      end else if (!will_write && hi_cnt != 0) begin
        n_fail++;
        $display("FAIL load_press_ignored got pulses=%0d, required 0", hi_cnt);
      end
    end
    if (with_run) begin
      n_tests++;
      if (tog_k != DB + 2 || cpu_at_tog !== !nxt_loading) begin
        n_fail++;
        $display("FAIL run_press_timing got edge=%0d cpu_nReset=%b, required edge=%0d cpu_nReset=%b",
                 tog_k, cpu_at_tog, DB + 2, !nxt_loading);
      end
    end
    n_tests++;
    if (bus.loading !== exp_loading || bus.cpu_nReset !== !exp_loading || bus.full !== exp_full) begin
      n_fail++;
      $display("FAIL state_after_press got loading=%b cpu_nReset=%b full=%b, required %b %b %b",
               bus.loading, bus.cpu_nReset, bus.full, exp_loading, !exp_loading, exp_full);
    end
    $display("[TB] press load=%b run=%b sw=%0h -> loading=%b full=%b", with_load, with_run, sw,
             bus.loading, bus.full);
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    bus.SW = '0; bus.load_btn = 1'b0; bus.run_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.loading !== 1'b1 || bus.cpu_nReset !== 1'b0 || bus.wr_en !== 1'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got loading=%b cpu_nReset=%b wr_en=%b addr=%0h data=%0h full=%b, required 1 0 0 0 0 0",
               bus.loading, bus.cpu_nReset, bus.wr_en, bus.wr_addr, bus.wr_data, bus.full);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    n_tests++;
    if (bus.checksum !== '0) begin
      n_fail++;
      $display("FAIL reset_checksum got %0h, required 0", bus.checksum);
    end
`endif
    do_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    @(negedge clk);
    bus.SW = 8'h99; bus.load_btn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    nReset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.loading !== 1'b1 || bus.cpu_nReset !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_press got loading=%b cpu_nReset=%b wr_en=%b addr=%0h, required 1 0 0 0",
               bus.loading, bus.cpu_nReset, bus.wr_en, bus.wr_addr);
    end
    @(negedge clk);
    bus.load_btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_lost_press got pulses=%0d, required 0", pulses);
    end
    press(8'h5A, 1'b1, 1'b0);
    $display("[TB] reset mid-press done");
  endtask

  task automatic test_bounce();
    int pulses;
    do_reset();
    sb_q.push_back({2'd0, 8'hC3});
    exp_addr  = 1;
    exp_cksum = 8'hC3;
    pulses = 0;
    @(negedge clk);
    bus.SW = 8'hC3;
    bus.load_btn = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; if (bus.wr_en === 1'b1) pulses++; end
    @(negedge clk); bus.load_btn = 1'b0;
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; if (bus.wr_en === 1'b1) pulses++; end
    @(negedge clk); bus.load_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; if (bus.wr_en === 1'b1) pulses++; end
    @(negedge clk); bus.load_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (bus.wr_en === 1'b1) pulses++; end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulses got %0d, required 1", pulses);
    end
    $display("[TB] bounce sequence: %0d write pulse(s)", pulses);
  endtask

  task automatic test_load_three_and_full();
    do_reset();
    press(8'h21, 1'b1, 1'b0);
    press(8'h42, 1'b1, 1'b0);
    press(8'h63, 1'b1, 1'b0);
    press(8'h84, 1'b1, 1'b0);   // last address, full rises with it
    press(8'hA5, 1'b1, 1'b0);   // blocked by full
    n_tests++;
    if (bus.wr_addr !== 2'd3 || bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold got addr=%0h full=%b, required addr=3 full=1", bus.wr_addr, bus.full);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    press(8'h11, 1'b1, 1'b0);
    press(8'h22, 1'b1, 1'b0);
    press('0, 1'b0, 1'b1);      // to RUN
    press(8'h33, 1'b1, 1'b0);   // ignored in RUN
    press('0, 1'b0, 1'b1);      // back to LOAD, addr cleared
    press(8'h44, 1'b1, 1'b0);   // writes addr 0
    press(8'h77, 1'b1, 1'b1);   // simultaneous: write addr 1, then RUN
    press('0, 1'b0, 1'b1);      // back to LOAD
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    press(8'hF0, 1'b1, 1'b0);
    press(8'h20, 1'b1, 1'b0);
    n_tests++;
    if (bus.checksum !== 8'h10) begin
      n_fail++;
      $display("FAIL checksum_sum got %0h, required 10", bus.checksum);
    end
    press('0, 1'b0, 1'b1);
    press('0, 1'b0, 1'b1);
    n_tests++;
    if (bus.checksum !== exp_cksum) begin
      n_fail++;
      $display("FAIL checksum_clear got %0h, required %0h", bus.checksum, exp_cksum);
    end
    $display("[TB] checksum checked");
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_bounce();
    test_load_three_and_full();
    test_handoff();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes got %0d outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
